// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first WIDTH-bit subtractor with start/busy/done handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH = 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             br_next;
  logic             last;

  // Full-subtractor bit cell fed from the operand LSBs and the borrow flop.
  assign a_i     = a_sh[0];
  assign b_i     = b_sh[0];
  assign d_i     = a_i ^ b_i ^ br;
  assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  assign last    = (cnt == CW'(WIDTH - 1));

  // Result bits enter at the MSB so bit 0 lands in the LSB after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = d_i;
    end else begin : g_res_wn
      assign res_next = {d_i, res[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, one bit per SHIFT cycle, result hand-off on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_next;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (last) begin
            diff   <= res_next;
            borrow <= br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;

  int tests;
  int fails;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation with fixed latency: accept, 8 busy cycles, one done cycle, back to idle.
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                     input logic [7:0] ed, input logic eb, input string tag);
    int bad;
    bad   = 0;
    start = 1'b1;
    a     = ai;
    b     = bi;
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      if (!(busy === 1'b1 && done === 1'b0)) bad++;
      tick();
    end
    check({tag, "_busy"}, bad, 0);
    check({tag, "_done"}, {busy, done}, 2'b01);
    check({tag, "_res"}, {borrow, diff}, {eb, ed});
    tick();
    check({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  // One WIDTH=1 operation: busy in cycle 1, done in cycle 2.
  task automatic op1(input logic ai, input logic bi, input logic ed, input logic eb, input string tag);
    start1 = 1'b1;
    a1     = ai;
    b1     = bi;
    tick();
    start1 = 1'b0;
    a1     = ~ai;
    b1     = ~bi;
    check({tag, "_c1"}, {busy1, done1}, 2'b10);
    tick();
    check({tag, "_c2"}, {busy1, done1, diff1, borrow1}, {2'b01, ed, eb});
    tick();
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       b_c1;
    logic       d_c9;
    logic       b_c9;
    logic       d_c10;
    logic       b_c10;
    int         hold_bad;
    int         rnd_bad;

    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;

    tick();
    tick();
    check("rst8", {busy, done, diff, borrow}, 11'd0);
    check("rst1", {busy1, done1, diff1, borrow1}, 4'd0);
    rst = 1'b0;
    tick();
    check("idle8", {busy, done}, 2'b00);

    op8(8'd200, 8'd55, 8'h91, 1'b0, "200m55");
    op8(8'd5, 8'd9, 8'hFC, 1'b1, "5m9");
    op8(8'hFF, 8'hFF, 8'h00, 1'b0, "ffmff");
    op8(8'd0, 8'd1, 8'hFF, 1'b1, "0m1");

    // Start re-asserted mid-operation with new operands must be ignored;
    // the previous result (0xFF, borrow 1) stays visible until done.
    hold_bad = 0;
    start = 1'b1;
    a     = 8'd100;
    b     = 8'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    a     = 8'd7;
    b     = 8'd7;
    tick();
    start = 1'b0;
    a     = 8'd33;
    b     = 8'd200;
    for (int i = 4; i <= 8; i++) begin
      if (!(busy === 1'b1 && diff === 8'hFF && borrow === 1'b1)) hold_bad++;
      tick();
    end
    check("ign_hold", hold_bad, 0);
    check("ign_res", {done, borrow, diff}, {1'b1, 1'b0, 8'd99});
    tick();
    check("ign_idle", {busy, done}, 2'b00);

    // Reset in the middle of SHIFT.
    start = 1'b1;
    a     = 8'd10;
    b     = 8'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst", {busy, done, diff, borrow}, 11'd0);
    tick();
    check("midrst_idle", {busy, done}, 2'b00);
    op8(8'd10, 8'd3, 8'd7, 1'b0, "after_rst");

    // WIDTH = 1: registered half subtractor.
    op1(1'b0, 1'b0, 1'b0, 1'b0, "w1_00");
    op1(1'b0, 1'b1, 1'b1, 1'b1, "w1_01");
    op1(1'b1, 1'b0, 1'b1, 1'b0, "w1_10");
    op1(1'b1, 1'b1, 1'b0, 1'b0, "w1_11");

    // Back-to-back random operations with start held high: one accept per 10 cycles.
    rnd_bad = 0;
    start   = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      a  = ra;
      b  = rb;
      tick();
      a    = 8'($urandom);
      b    = 8'($urandom);
      b_c1 = busy;
      repeat (8) tick();
      d_c9 = done;
      b_c9 = busy;
      if ({borrow, diff} !== {(ra < rb), 8'(ra - rb)}) begin
        rnd_bad++;
        if (rnd_bad <= 5)
          $display("FAIL rnd_val a=%0d b=%0d got diff=%0d borrow=%0b", ra, rb, diff, borrow);
      end
      tick();
      d_c10 = done;
      b_c10 = busy;
      check("rnd_hs", {b_c1, d_c9, b_c9, d_c10, b_c10}, 5'b11000);
    end
    start = 1'b0;
    check("rnd_val", rnd_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock. It reuses one half/full-subtractor bit cell and a borrow flip-flop, so it is the inverse arithmetic operation of the team's adder cells. It sits beside the adder blocks in the arithmetic library and uses a start/busy/done handshake so a controller or bench can sequence operations.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new subtraction; sampled only in IDLE.
a  input  WIDTH  minuend; sampled on the accepted start edge.
b  input  WIDTH  subtrahend; sampled on the accepted start edge.
busy  output  1  high while bits are being processed (SHIFT state).
done  output  1  one-cycle pulse; diff and borrow are valid from this cycle.
diff  output  WIDTH  a - b modulo 2^WIDTH.
borrow  output  1  final borrow out; 1 when a < b (unsigned).

Behaviour:
- One clock. Reset is synchronous and active-high: clk and rst.
- Reset sets state = IDLE and clears busy, done, diff, borrow, the internal shift registers, the borrow flop and the bit counter. Reset has priority over every other event, including reset asserted in the middle of an operation. Operation resumes from IDLE on the first edge after rst deasserts.
- States:
  - IDLE -> SHIFT on start = 1. On that edge: latch a and b into shift registers, clear the borrow flop and result register, and set the counter to 0. start = 0 stays in IDLE.
  - SHIFT: busy = 1. Each cycle processes bit i = LSB of each shift register:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the result register MSB-first, so after WIDTH shifts bit 0 is in the LSB.
    - The operand registers shift right and the counter increments.
    - When the counter reaches WIDTH-1, that edge transfers the final result to diff and br_next to borrow, and moves to DONE.
  - DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE unconditionally.
- diff and borrow hold their values from DONE until the next DONE or reset. They do not change during a later SHIFT; the working result register is separate.
- Latency: start accepted on edge 0, busy high for cycles 1..WIDTH, done high in cycle WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy or in DONE is ignored, and a/b changes after acceptance have no effect. To be accepted, start must be high in IDLE.
- busy and done are never high together.
- WIDTH = 1: one SHIFT cycle. The block behaves as a registered half subtractor: diff = a ^ b, borrow = ~a & b.
- Counter width is $clog2(WIDTH) bits, with a minimum of 1.

Test Plan:
- WIDTH=8, a=200, b=55, start pulse 1 cycle -> busy high 8 cycles; done in cycle 9 after accept; diff=145 (0x91), borrow=0.
- WIDTH=8, a=5, b=9 -> diff=0xFC, borrow=1. Also a=0, b=1 -> diff=0xFF, borrow=1. Also a=0xFF, b=0xFF -> diff=0x00, borrow=0.
- WIDTH=8, start a=100, b=1; at cycle 3 assert start with a=7, b=7 and change the inputs -> ignored; done gives diff=99, borrow=0. Previous diff is held until that done.
- WIDTH=8, start a=10, b=3; assert rst at cycle 4 of SHIFT for 1 cycle -> next cycle busy=0, done=0, diff=0, borrow=0, state IDLE. A fresh start then gives diff=7 with normal latency.
- WIDTH=1, run all four inputs (a,b) = 00, 01, 10, 11 -> (diff,borrow) = 00, 11, 10, 00. Done must arrive 2 cycles after each accepted start.
- Random check, WIDTH=8: 1000 back-to-back operations with start held high -> each accepted exactly once per 10 cycles; diff equals (a-b) mod 256 and borrow equals (a<b).
